paralelo_serial_tx: RTL and testbench
=====================================

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 The block SHALL take parameter IDLE_CHAR, default 8'hBC, the byte sent whenever no valid data is available (COM idle symbol).
REQ-002 The block SHALL take parameter SYNC_BYTES, default 4, legal range 1..8: the number of IDLE_CHAR bytes forced after reset before data is accepted.
REQ-003 clk_32f  input  1  sole clock; one serial bit per rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising clk_32f only.
REQ-005 data_in  input  8  parallel byte to serialize.
REQ-006 valid_in  input  1  data_in qualifier.
REQ-007 data_out  output  1  serial stream, MSB first; feeds serial_paralelo data_in.
REQ-008 byte_req  output  1  high for the one cycle whose closing edge samples data_in/valid_in.
REQ-009 active  output  1  high once the sync preamble has been sent and data is accepted.

Function
REQ-010 The block SHALL use a 3-bit bit counter bit_cnt, an 8-bit current-byte register cur_byte, a sync counter sync_cnt (3 bits) and a 2-state FSM {SYNC, RUN}.
REQ-011 Every non-reset edge SHALL do data_out <= cur_byte[7-bit_cnt] and bit_cnt <= bit_cnt+1, wrapping 7->0.
REQ-012 The edge with bit_cnt==7 is the byte boundary; only there SHALL cur_byte be reloaded.
REQ-013 SYNC rule: at a boundary, cur_byte <= IDLE_CHAR, valid_in/data_in ignored.
REQ-014 RUN rule: at a boundary, cur_byte <= valid_in ? data_in : IDLE_CHAR.
REQ-015 In SYNC, each boundary SHALL increment sync_cnt; at the boundary where sync_cnt==SYNC_BYTES-1 the FSM SHALL move to RUN and that boundary SHALL already apply the RUN rule.
REQ-016 Consequently exactly SYNC_BYTES IDLE_CHAR bytes (reset-loaded byte included) SHALL precede the first possible data byte.
REQ-017 RUN SHALL be left only by reset.
REQ-018 byte_req SHALL equal (bit_cnt==7) && (state==RUN || sync_cnt==SYNC_BYTES-1), decoded from registers only (no input-to-output path).
REQ-019 active SHALL be registered, 1 iff state==RUN.
REQ-020 Latency: a byte sampled at boundary edge E SHALL appear on data_out bit7 after edge E+1 through bit0 after edge E+8, contiguous with neighbouring bytes (no gap bits).
REQ-021 valid_in high outside byte_req cycles SHALL have no effect; data_in need only be stable at the boundary edge.
REQ-022 Back-to-back valid bytes SHALL be serialized every 8 cycles with no idle inserted.

Reset
REQ-023 On reset: bit_cnt=0, cur_byte=IDLE_CHAR, sync_cnt=0, state=SYNC, data_out=0, active=0; byte_req=0 follows from bit_cnt=0.
REQ-024 Reset asserted mid-byte SHALL abandon the byte in flight and restart the full sync preamble; no partial byte is resumed.
REQ-025 Reset held for multiple cycles SHALL keep all outputs at reset values.

Verification
REQ-026 Reset 2 cycles, valid_in=0 for 64 cycles -> data_out repeats 10111100 from the first edge after release; active rises at edge 32 (1-based count from release); byte_req first high in cycle 32.
REQ-027 valid_in=1, data_in=8'hA5 held from reset -> first 32 bits are 4x 8'hBC (valid ignored), then 10100101 repeated; active=1 from edge 32.
REQ-028 In RUN, supply 8'h01, 8'hFF, 8'h00 on three consecutive byte_req cycles, then valid_in=0 -> stream 00000001 11111111 00000000 10111100 with no gap bits.
REQ-029 Pulse valid_in=1 with 8'h3C for one cycle not coinciding with byte_req -> only IDLE_CHAR transmitted.
REQ-030 Assert reset at bit_cnt==4 of a data byte -> data_out=0 during reset; after release, 4 IDLE_CHAR bytes resent and active=0 until edge 32.
REQ-031 Loopback into serial_paralelo, 256-byte counting pattern -> serial_paralelo active asserts after the preamble and data_out reproduces every byte in order.

Source files
------------

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: serializes bytes MSB first, one bit per clock.
// After reset a preamble of SYNC_BYTES idle symbols is sent before data is accepted.
module paralelo_serial_tx #(
    parameter logic [7:0] IDLE_CHAR  = 8'hBC,
    parameter int         SYNC_BYTES = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       byte_req,
    output logic       active
);

    localparam logic [2:0] LAST_SYNC = 3'(SYNC_BYTES - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [2:0] sync_cnt;
    logic [7:0] cur_byte;
    logic       boundary;
    logic       load_slot;

    // The last preamble boundary already accepts data, so the first data byte
    // directly follows the final idle byte with no gap.
    assign boundary  = (bit_cnt == 3'd7);
    assign load_slot = (state == RUN) || (sync_cnt == LAST_SYNC);
    assign byte_req  = boundary && load_slot;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= SYNC;
            bit_cnt  <= 3'd0;
            sync_cnt <= 3'd0;
            cur_byte <= IDLE_CHAR;
            data_out <= 1'b0;
            active   <= 1'b0;
        end else begin
            data_out <= cur_byte[3'd7 - bit_cnt];
            bit_cnt  <= bit_cnt + 3'd1;
            if (boundary) begin
                cur_byte <= (load_slot && valid_in) ? data_in : IDLE_CHAR;
                if (state == SYNC) begin
                    sync_cnt <= sync_cnt + 3'd1;
                    if (sync_cnt == LAST_SYNC) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: table-driven byte sequences,
// hand-written reset corner cases and random traffic against a stream model.
module tb_paralelo_serial_tx;

    localparam logic [7:0] IDLE_CHAR  = 8'hBC;
    localparam int         SYNC_BYTES = 4;

    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out;
    logic       byte_req;
    logic       active;

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset release and the list of bytes
    // that occupy each 8-edge slot of the output stream.
    int         edge_num = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] rx_shift = 8'h00;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       pulse_only;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl[9];

    paralelo_serial_tx #(
        .IDLE_CHAR (IDLE_CHAR),
        .SYNC_BYTES(SYNC_BYTES)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .valid_in(valid_in),
        .data_out(data_out),
        .byte_req(byte_req),
        .active  (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: actual=%0h expected=%0h", name, edge_num, act, exp);
        end
    endtask

    // One clock with reset low: predicts byte_req, applies inputs, then checks
    // the serial bit and active against the byte-slot model.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        int         e;
        int         k;
        int         b;
        logic [7:0] slot;
        @(negedge clk_32f);
        reset    = 1'b0;
        valid_in = v;
        data_in  = d;
        e = edge_num + 1;
        checkOutput("byte_req", {31'd0, byte_req}, {31'd0, (e % 8 == 0) && (e / 8 >= SYNC_BYTES)});
        @(posedge clk_32f);
        edge_num = e;
        if (e % 8 == 0)
            exp_bytes.push_back(((e / 8 >= SYNC_BYTES) && v) ? d : IDLE_CHAR);
        #1;
        k = (e - 1) / 8;
        b = 7 - ((e - 1) % 8);
        slot = exp_bytes[k];
        checkOutput("data_out", {31'd0, data_out}, {31'd0, slot[b]});
        checkOutput("active", {31'd0, active}, {31'd0, e >= 8 * SYNC_BYTES});
        rx_shift = {rx_shift[6:0], data_out};
    endtask

    task automatic doReset(input int n);
        repeat (n) begin
            @(negedge clk_32f);
            reset    = 1'b1;
            valid_in = 1'($urandom);
            data_in  = 8'($urandom);
            @(posedge clk_32f);
            #1;
            checkOutput("reset_data_out", {31'd0, data_out}, 32'd0);
            checkOutput("reset_active", {31'd0, active}, 32'd0);
            checkOutput("reset_byte_req", {31'd0, byte_req}, 32'd0);
        end
        edge_num = 0;
        exp_bytes.delete();
        exp_bytes.push_back(IDLE_CHAR);
    endtask

    // Eight cycles aligned to a byte slot; valid is either held for the whole
    // slot or pulsed once away from the byte_req cycle.
    task automatic runBlock(input vec_t vec);
        for (int c = 0; c < 8; c++) begin
            if (vec.pulse_only)
                applyStimulus(c == 2, vec.data);
            else
                applyStimulus(vec.valid, vec.data);
        end
    endtask

    initial begin
        vec_t tmp;

        tbl[0] = '{valid: 1'b1, data: 8'h01, pulse_only: 1'b0, exp_byte: 8'h01};
        tbl[1] = '{valid: 1'b1, data: 8'hFF, pulse_only: 1'b0, exp_byte: 8'hFF};
        tbl[2] = '{valid: 1'b1, data: 8'h00, pulse_only: 1'b0, exp_byte: 8'h00};
        tbl[3] = '{valid: 1'b0, data: 8'h00, pulse_only: 1'b0, exp_byte: 8'hBC};
        tbl[4] = '{valid: 1'b1, data: 8'h3C, pulse_only: 1'b1, exp_byte: 8'hBC};
        tbl[5] = '{valid: 1'b1, data: 8'h7E, pulse_only: 1'b0, exp_byte: 8'h7E};
        tbl[6] = '{valid: 1'b0, data: 8'h55, pulse_only: 1'b0, exp_byte: 8'hBC};
        tbl[7] = '{valid: 1'b1, data: 8'h80, pulse_only: 1'b1, exp_byte: 8'hBC};
        tbl[8] = '{valid: 1'b1, data: 8'h80, pulse_only: 1'b0, exp_byte: 8'h80};

        // Idle stream after a 2-cycle reset: preamble then repeated idle symbols.
        doReset(2);
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 8; c++) applyStimulus(1'b0, 8'h00);
            checkOutput("idle_byte", {24'd0, rx_shift}, {24'd0, 8'hBC});
        end

        // Valid data held from reset: ignored through the preamble.
        doReset(3);
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 8; c++) applyStimulus(1'b1, 8'hA5);
            checkOutput("held_valid_byte", {24'd0, rx_shift}, (blk < SYNC_BYTES) ? 32'hBC : 32'hA5);
        end

        // Table-driven byte sequence; each byte is observed one slot later.
        doReset(1);
        for (int c = 0; c < 8 * SYNC_BYTES; c++) applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            runBlock(tbl[i]);
            if (i > 0)
                checkOutput("table_byte", {24'd0, rx_shift}, {24'd0, tbl[i-1].exp_byte});
        end
        tmp = '{valid: 1'b0, data: 8'h00, pulse_only: 1'b0, exp_byte: 8'hBC};
        runBlock(tmp);
        checkOutput("table_byte", {24'd0, rx_shift}, {24'd0, tbl[8].exp_byte});

        // Reset in the middle of a data byte restarts the whole preamble.
        while (edge_num % 8 != 4) applyStimulus(1'b1, 8'h5A);
        doReset(3);
        for (int c = 0; c < 8 * SYNC_BYTES + 16; c++) applyStimulus(1'b1, 8'hC3);
        checkOutput("post_reset_active", {31'd0, active}, 32'd1);

        // Back-to-back counting pattern with no idle between bytes.
        doReset(1);
        for (int c = 0; c < 8 * SYNC_BYTES; c++) applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            tmp = '{valid: 1'b1, data: 8'(i), pulse_only: 1'b0, exp_byte: 8'(i)};
            runBlock(tmp);
            if (i > 0)
                checkOutput("count_byte", {24'd0, rx_shift}, 32'(i - 1));
        end
        tmp = '{valid: 1'b0, data: 8'h00, pulse_only: 1'b0, exp_byte: 8'hBC};
        runBlock(tmp);
        checkOutput("count_byte", {24'd0, rx_shift}, 32'd255);

        // Random traffic checked purely by the stream model, with random resets.
        for (int r = 0; r < 3; r++) begin
            doReset(1 + int'($urandom_range(0, 2)));
            for (int c = 0; c < 300; c++)
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
